// File: rtl/pixel_packer.sv
// pixel_packer: packs an R,G,B byte stream into 18-bit {R6,G6,B6} frame-buffer writes.
//
// Ports:
//   clk, reset (async, active-low)   - clock and reset
//   clear                            - synchronous frame restart
//   rx_data[7:0], rx_ready           - received byte and its one-cycle strobe
//   wr_en, wr_addr, raw_rgb          - frame-buffer write port (wr_en one cycle per pixel)
//   frame_done                       - pulses with the write of the last pixel of a frame
//   busy                             - frame in progress
//   sync_err                         - pulses when a stalled partial pixel is discarded
//
// Optional feature: define PACKER_TIMEOUT_EN to build the mid-pixel idle timeout.
// Without it sync_err is tied low and a partial pixel waits indefinitely.
module pixel_packer #(
  parameter int unsigned IMG_W          = 320,
  parameter int unsigned IMG_H          = 240,
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [17:0]       raw_rgb,
  output logic              frame_done,
  output logic              busy,
  output logic              sync_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    WAIT_R = 2'd0,
    WAIT_G = 2'd1,
    WAIT_B = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        r_hold_q, r_hold_d;
  logic [5:0]        g_hold_q, g_hold_d;
  logic [17:0]       raw_rgb_q, raw_rgb_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              timeout_c;

  // The two LSBs of each channel byte are dropped by design.
  logic unused_lsbs;
  assign unused_lsbs = ^rx_data[1:0];

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] idle_q, idle_d;
  logic          sync_err_q, sync_err_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a partial pixel.
  assign timeout_c = (state_q != WAIT_R) && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: cleared by any byte, by resync and while waiting for red.
  always_comb begin
    idle_d     = idle_q + TW'(1);
    sync_err_d = timeout_c && !clear;
    if (clear || rx_ready || timeout_c || (state_q == WAIT_R)) begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      idle_q     <= idle_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign timeout_c = 1'b0;
  assign sync_err  = 1'b0;
`endif

  // Byte sequencing, pixel packing and address generation.
  always_comb begin
    state_d      = state_q;
    r_hold_d     = r_hold_q;
    g_hold_d     = g_hold_q;
    raw_rgb_d    = raw_rgb_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    wr_addr_d    = wr_addr_q;

    // Address advances as the write cycle ends, wrapping after the last pixel.
    if (wr_en_q) begin
      wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
    end

    if (clear) begin
      state_d   = WAIT_R;
      wr_addr_d = '0;
    end else if (timeout_c) begin
      // Resync; a byte arriving in the same cycle starts a new pixel.
      state_d = WAIT_R;
      if (rx_ready) begin
        r_hold_d = rx_data[7:2];
        state_d  = WAIT_G;
      end
    end else if (rx_ready) begin
      case (state_q)
        WAIT_R: begin
          r_hold_d = rx_data[7:2];
          state_d  = WAIT_G;
        end
        WAIT_G: begin
          g_hold_d = rx_data[7:2];
          state_d  = WAIT_B;
        end
        WAIT_B: begin
          raw_rgb_d    = {r_hold_q, g_hold_q, rx_data[7:2]};
          wr_en_d      = 1'b1;
          frame_done_d = (wr_addr_d == LAST_ADDR);
          state_d      = WAIT_R;
        end
        default: state_d = WAIT_R;
      endcase
    end

    busy_d = (state_d != WAIT_R) || (wr_addr_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_R;
      r_hold_q     <= '0;
      g_hold_q     <= '0;
      raw_rgb_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_hold_q     <= r_hold_d;
      g_hold_q     <= g_hold_d;
      raw_rgb_q    <= raw_rgb_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign raw_rgb    = raw_rgb_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: scoreboard bench for pixel_packer (IMG_W=4, IMG_H=2, TIMEOUT_CYCLES=16).
module tb_pixel_packer;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [17:0]   raw_rgb;
  logic          frame_done;
  logic          busy;
  logic          sync_err;

  pixel_packer #(
    .IMG_W(4), .IMG_H(2), .ADDR_W(AW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .rx_data(rx_data), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .raw_rgb(raw_rgb), .frame_done(frame_done),
    .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0]   rgb;
    logic [AW-1:0] addr;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   sync_cnt = 0;

  // Bench-side pixel model
  int          phase = 0;
  logic [5:0]  r_m, g_m;
  int          addr_m = 0;
  logic [17:0] last_rgb = '0;

  always @(posedge clk) cyc++;

  // Monitor: compare every write against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (sync_err) sync_cnt++;
      if (wr_en) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%0d rgb=%h, want no write", wr_addr, raw_rgb);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (raw_rgb !== e.rgb || wr_addr !== e.addr || frame_done !== e.done || cyc != e.cyc) begin
            bad++;
            $display("FAIL write: got rgb=%h addr=%0d done=%b cyc=%0d, want rgb=%h addr=%0d done=%b cyc=%0d",
                     raw_rgb, wr_addr, frame_done, cyc, e.rgb, e.addr, e.done, e.cyc);
          end
        end
      end else if (frame_done) begin
        total++;
        bad++;
        $display("FAIL stray_frame_done: got 1, want 0 (no write)");
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for one edge; clr drives clear in the same cycle.
  task automatic send(input logic [7:0] b, input logic clr);
    exp_t e;
    rx_data  = b;
    rx_ready = 1'b1;
    clear    = clr;
    if (clr) begin
      phase  = 0;
      addr_m = 0;
    end else begin
      case (phase)
        0: r_m = b[7:2];
        1: g_m = b[7:2];
        default: begin
          e.rgb  = {r_m, g_m, b[7:2]};
          e.addr = AW'(addr_m);
          e.done = (addr_m == 7);
          e.cyc  = cyc + 1;
          sb.push_back(e);
          last_rgb = e.rgb;
          addr_m   = (addr_m + 1) % 8;
        end
      endcase
      phase = (phase + 1) % 3;
    end
    tick();
    rx_ready = 1'b0;
    clear    = 1'b0;
    rx_data  = 8'hA5;
  endtask

  initial begin
    reset    = 1'b0;
    clear    = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (2) tick();
    chk("reset_wr_en", 32'(wr_en), 0);
    chk("reset_wr_addr", 32'(wr_addr), 0);
    chk("reset_raw_rgb", 32'(raw_rgb), 0);
    chk("reset_busy_done_sync", {29'd0, busy, frame_done, sync_err}, 0);
    #3 reset = 1'b1;
    tick();

    // Single pixel with gaps between bytes
    send(8'hFC, 1'b0); tick(); tick();
    send(8'h80, 1'b0); tick();
    send(8'h04, 1'b0);
    chk("t1_raw_rgb_const", 32'(raw_rgb), 32'h3F801);
    tick();
    chk("t1_addr_after", 32'(wr_addr), 1);
    chk("t1_busy_after", 32'(busy), 1);

    // Restart frame, then a full frame of back-to-back bytes
    clear = 1'b1; addr_m = 0; phase = 0;
    tick();
    clear = 1'b0;
    chk("clear_addr", 32'(wr_addr), 0);
    for (int i = 0; i < 24; i++) send(8'(i * 37 + 5), 1'b0);
    chk("frame_busy_last", 32'(busy), 1);
    tick();
    chk("frame_addr_wrap", 32'(wr_addr), 0);
    chk("frame_busy_idle", 32'(busy), 0);

    // Clear together with the blue byte drops the pixel
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    tick(); tick();
    chk("clr_addr", 32'(wr_addr), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_rgb_kept", 32'(raw_rgb), 32'(last_rgb));
    send(8'h48, 1'b0); send(8'h8C, 1'b0); send(8'hF0, 1'b0);
    tick();
    chk("clr_next_addr", 32'(wr_addr), 1);

    // Asynchronous reset between green and blue
    send(8'hFF, 1'b0); send(8'hFF, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_addr", 32'(wr_addr), 0);
    chk("rst_async_rgb", 32'(raw_rgb), 0);
    chk("rst_async_flags", {28'd0, wr_en, busy, frame_done, sync_err}, 0);
    #2 reset = 1'b1;
    phase = 0; addr_m = 0;
    tick();
    send(8'h04, 1'b0); send(8'h08, 1'b0); send(8'h0C, 1'b0);
    tick();
    chk("rst_next_addr", 32'(wr_addr), 1);

    // Stalled partial pixel
    sync_cnt = 0;
    send(8'h40, 1'b0);
    repeat (20) tick();
    chk("idle_addr_kept", 32'(wr_addr), 1);
`ifdef PACKER_TIMEOUT_EN
    chk("idle_sync_err", 32'(sync_cnt), 1);
    chk("idle_busy", 32'(busy), 1);
    phase = 0;
    send(8'hC0, 1'b0); send(8'h30, 1'b0); send(8'h0C, 1'b0);
`else
    chk("idle_sync_err", 32'(sync_cnt), 0);
    chk("idle_busy", 32'(busy), 1);
    send(8'h30, 1'b0); send(8'h0C, 1'b0);
`endif
    tick();
    chk("idle_next_addr", 32'(wr_addr), 2);

    // Drain: every expected write must have been observed
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Upstream feeder for the channel-mask/colour-reduction stage.
- Takes the UART receiver's byte stream (one byte per channel, R, G, B order) and keeps the 6 MSBs of each byte.
- Packs each pixel into an 18-bit {R6,G6,B6} word and issues one write per pixel into the frame buffer at a sequential address.
- The frame-buffer read side later presents this word as the 18-bit raw pixel to the editor stage.

Parameters:
- IMG_W, 320, image width in pixels.
- IMG_H, 240, image height in pixels.
- ADDR_W, 17, frame-buffer address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.
- TIMEOUT_CYCLES, 1000000, idle clocks mid-pixel before resync (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- clear  in  1  synchronous frame restart.
- rx_data  in  8  received byte.
- rx_ready  in  1  one-cycle strobe; rx_data is valid this cycle.
- wr_en  out  1  frame-buffer write strobe, one cycle.
- wr_addr  out  ADDR_W  write address.
- raw_rgb  out  18  packed pixel {R[5:0],G[5:0],B[5:0]}.
- frame_done  out  1  one-cycle pulse on the last pixel write of a frame.
- busy  out  1  frame in progress.
- sync_err  out  1  one-cycle pulse on timeout resync (0 when the feature is off).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=WAIT_R; R/G channel holding registers=0.
  - wr_en=0, wr_addr=0, raw_rgb=0, frame_done=0, busy=0, sync_err=0.
- FSM states WAIT_R -> WAIT_G -> WAIT_B -> WAIT_R. Each transition occurs only on a clock edge with rx_ready=1.
  - WAIT_R + rx_ready: r_hold<=rx_data[7:2]; go to WAIT_G.
  - WAIT_G + rx_ready: g_hold<=rx_data[7:2]; go to WAIT_B.
  - WAIT_B + rx_ready: raw_rgb<={r_hold,g_hold,rx_data[7:2]}; wr_en<=1 next cycle; go to WAIT_R.
- Write latency: wr_en is high exactly one cycle, the cycle after the blue byte's rx_ready.
  - raw_rgb and wr_addr are stable during that cycle.
  - raw_rgb holds its value until the next pixel completes.
- Address handling:
  - wr_addr increments on the clock edge ending the wr_en cycle.
  - If wr_addr == IMG_W*IMG_H-1 during wr_en: frame_done=1 in that same cycle, and wr_addr wraps to 0.
- Back-to-back bytes: rx_ready may be high on consecutive cycles, including during the wr_en cycle. No byte is dropped; throughput is one byte per clock.
- busy = (state != WAIT_R) || (wr_addr != 0). It drops to 0 the cycle after frame_done.
- clear=1 (synchronous):
  - Next state WAIT_R, wr_addr<=0.
  - Discards any partial pixel and suppresses a pending wr_en.
  - raw_rgb keeps its value.
  - clear has priority over a simultaneous rx_ready; that byte is dropped.
- Mid-operation reset: asynchronous return to reset values. A wr_en cycle in flight is aborted.
- rx_data is ignored whenever rx_ready=0.

Optional Feature:
- Macro: PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter runs while state is WAIT_G or WAIT_B. It resets to 0 on every accepted byte and on every entry into WAIT_R.
  - On reaching TIMEOUT_CYCLES: state<=WAIT_R, the partial pixel is discarded, wr_addr is unchanged, and sync_err pulses for one cycle.
  - rx_ready in the same cycle as the timeout is treated as a new red byte.
- Undefined:
  - No counter is built; a partial pixel waits indefinitely.
  - sync_err is tied to 0.

Test Plan (IMG_W=4, IMG_H=2, TIMEOUT_CYCLES=16):
- Reset, then bytes 0xFC,0x80,0x04 with gaps -> one wr_en cycle after the third strobe with raw_rgb=18'h3F801 ({3F,20,01}) and wr_addr=0; wr_addr=1 afterwards.
- 24 bytes on consecutive cycles -> wr_en on cycles 3,6,...,24 with addresses 0..7; frame_done coincides with addr 7; wr_addr=0 and busy=0 after.
- Two bytes sent, then clear together with a third byte -> no wr_en; wr_addr=0; the next three bytes write addr 0.
- Reset pulsed low between green and blue bytes -> all outputs 0 immediately (asynchronously), with no write; the following R,G,B triple writes addr 0.
- PACKER_TIMEOUT_EN: one byte, then 16 idle cycles -> sync_err pulse with wr_addr unchanged; the next 3 bytes form a correct pixel. Without the macro, the same stimulus gives no sync_err and the next 2 bytes complete the old pixel.
